// File: rtl/ethermac_pkg.sv
// Shared types and constants for the Ethernet MAC transmit arbiter.
package ethermac_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CHECK   = 2'd1,
      S_WAIT_DN = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam int PKG_MAX_LENGTH = 757;
   localparam int ADDR_W         = 10;
   localparam int DATA_W         = 16;
   localparam int PID_W          = 2;
   localparam int LEN_W          = 10;

   // Lengths the MAC would silently drop: zero or beyond its buffer limit.
   function automatic logic len_legal(input logic [LEN_W-1:0] len);
      return (len != '0) && (len <= LEN_W'(PKG_MAX_LENGTH));
   endfunction

endpackage

// File: rtl/ethermac_tx_arbiter_if.sv
// MAC-side bundle of the transmit arbiter: launch request, frame info, data and status.
interface ethermac_tx_arbiter_if;
   import ethermac_pkg::*;

   // Handshake: send_irq is a one-cycle launch while length/port_id stay stable;
   // it is only issued when send_idl is high, and the MAC ends the frame with a
   // one-cycle send_dn pulse. There is no back-pressure on send_irq itself.
   logic              send_irq;
   logic [LEN_W-1:0]  length;
   logic [PID_W-1:0]  port_id;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] mac_addr;
   logic              send_dn;
   logic              send_idl;

   modport master (
      output send_irq, length, port_id, data,
      input  mac_addr, send_dn, send_idl
   );

   modport slave (
      input  send_irq, length, port_id, data,
      output mac_addr, send_dn, send_idl
   );

endinterface

// File: rtl/ethermac_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module ethermac_rr_pick #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [1:0]         i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [1:0]         o_idx,
   output logic               o_valid
);

   // Two passes with constant indices: upper segment from the pointer, then the wrap.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_valid && i_req[k] && (2'(k) >= i_ptr)) begin
            o_valid    = 1'b1;
            o_grant[k] = 1'b1;
            o_idx      = 2'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_valid && i_req[k] && (2'(k) < i_ptr)) begin
            o_valid    = 1'b1;
            o_grant[k] = 1'b1;
            o_idx      = 2'(k);
         end
      end
   end

endmodule

// File: rtl/ethermac_tx_arbiter.sv
// Round-robin scheduler sharing one MII transmit MAC among NUM_REQ frame sources.
// Defining TX_ARB_TIMEOUT_EN adds a watchdog on the wait for send-done.
module ethermac_tx_arbiter
   import ethermac_pkg::*;
#(
   parameter int NUM_REQ = 3
`ifdef TX_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4095
`endif
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [LEN_W*NUM_REQ-1:0]  i_len,
   input  logic [DATA_W*NUM_REQ-1:0] i_rd_data,
   output logic [ADDR_W-1:0]         o_rd_addr,
   output logic [NUM_REQ-1:0]        o_grant,
   output logic [NUM_REQ-1:0]        o_done,
   output logic [NUM_REQ-1:0]        o_err,
   output logic                      o_timeout,
   output state_t                    o_dbg_state,
   ethermac_tx_arbiter_if.master     mac_if
);

   state_t              r_state, w_next;
   logic [1:0]          r_rr_ptr;
   logic [NUM_REQ-1:0]  r_grant, r_done, r_err;
   logic [PID_W-1:0]    r_port_id;
   logic [LEN_W-1:0]    r_length;
   logic                r_send_irq;

   logic [NUM_REQ-1:0]  w_pick_grant;
   logic [1:0]          w_pick_idx;
   logic                w_pick_valid;
   logic [LEN_W-1:0]    w_sel_len;
   logic [DATA_W-1:0]   w_data;
   logic                w_load, w_irq, w_fin_done, w_fin_err, w_tmo, w_release;
   logic                w_cnt_hit;

   ethermac_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   always_comb begin
      w_sel_len = '0;
      w_data    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_pick_idx == 2'(k)) w_sel_len = i_len[k*LEN_W +: LEN_W];
         if (r_grant[k])          w_data    = i_rd_data[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Send-done is checked before the watchdog so a late-but-valid finish wins.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_irq      = 1'b0;
      w_fin_done = 1'b0;
      w_fin_err  = 1'b0;
      w_tmo      = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pick_valid && mac_if.send_idl) begin
               w_load = 1'b1;
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (len_legal(r_length)) begin
               w_irq  = 1'b1;
               w_next = S_WAIT_DN;
            end else begin
               w_fin_err = 1'b1;
               w_next    = S_RELEASE;
            end
         end
         S_WAIT_DN: begin
            if (mac_if.send_dn) begin
               w_fin_done = 1'b1;
               w_next     = S_RELEASE;
            end else if (w_cnt_hit) begin
               w_fin_err = 1'b1;
               w_tmo     = 1'b1;
               w_next    = S_RELEASE;
            end
         end
         S_RELEASE: begin
            w_release = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_done     <= '0;
         r_err      <= '0;
         r_port_id  <= '0;
         r_length   <= '0;
         r_send_irq <= 1'b0;
      end else begin
         r_done     <= w_fin_done ? r_grant : '0;
         r_err      <= w_fin_err  ? r_grant : '0;
         r_send_irq <= w_irq;
         if (w_load) begin
            r_grant   <= w_pick_grant;
            r_port_id <= w_pick_idx;
            r_length  <= w_sel_len;
         end
         if (w_release) begin
            r_grant  <= '0;
            r_rr_ptr <= (r_port_id == 2'(NUM_REQ - 1)) ? '0 : r_port_id + 1'b1;
         end
      end
   end

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout;

   // Cleared on the launch edge, so the count equals cycles spent in S_WAIT_DN.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_irq)                     r_wait_cnt <= '0;
         else if (r_state == S_WAIT_DN) r_wait_cnt <= r_wait_cnt + 1'b1;
         if (w_tmo) r_timeout <= 1'b1;
      end
   end

   assign w_cnt_hit = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign o_timeout = r_timeout;
`else
   assign w_cnt_hit = 1'b0;
   assign o_timeout = 1'b0;
`endif

   assign o_rd_addr        = mac_if.mac_addr;
   assign o_grant          = r_grant;
   assign o_done           = r_done;
   assign o_err            = r_err;
   assign o_dbg_state      = r_state;
   assign mac_if.send_irq  = r_send_irq;
   assign mac_if.length    = r_length;
   assign mac_if.port_id   = r_port_id;
   assign mac_if.data      = w_data;

endmodule

// File: tb/tb_ethermac_tx_arbiter.sv
// Directed bench for ethermac_tx_arbiter; the watchdog scenario runs when TX_ARB_TIMEOUT_EN is defined.
module tb_ethermac_tx_arbiter;
   import ethermac_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [29:0] len_bus;
   logic [47:0] rd_bus;
   logic [9:0]  rd_addr;
   logic [2:0]  grant, done, err;
   logic        timeout;
   state_t      dbg_state;
   int          n_cmp = 0;
   int          n_bad = 0;

   ethermac_tx_arbiter_if mac_if ();

   ethermac_tx_arbiter #(
      .NUM_REQ(3)
`ifdef TX_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_len       (len_bus),
      .i_rd_data   (rd_bus),
      .o_rd_addr   (rd_addr),
      .o_grant     (grant),
      .o_done      (done),
      .o_err       (err),
      .o_timeout   (timeout),
      .o_dbg_state (dbg_state),
      .mac_if      (mac_if.master)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 500000");
      $fatal(1, "bench stalled");
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; len_bus = '0; rd_bus = '0;
      mac_if.mac_addr = '0; mac_if.send_dn = 1'b0; mac_if.send_idl = 1'b1;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic finish_frame();
      mac_if.send_dn = 1'b1;
      step();
      mac_if.send_dn = 1'b0;
      req = '0;
      step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
      n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL reset_done: got %b want 000", done); end
      n_cmp++; if (err !== 3'b000) begin n_bad++; $display("FAIL reset_err: got %b want 000", err); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      n_cmp++; if (mac_if.send_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", mac_if.send_irq); end
      n_cmp++; if (mac_if.length !== 10'd0) begin n_bad++; $display("FAIL reset_length: got %0d want 0", mac_if.length); end
      n_cmp++; if (mac_if.port_id !== 2'd0) begin n_bad++; $display("FAIL reset_port_id: got %0d want 0", mac_if.port_id); end
      n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
      n_cmp++; if (mac_if.data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", mac_if.data); end
   endtask

   task automatic test_single();
      do_reset();
      len_bus[9:0] = 10'd64;
      req = 3'b001;
      step();
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL single_grant: got %b want 001", grant); end
      n_cmp++; if (mac_if.send_irq !== 1'b0) begin n_bad++; $display("FAIL single_irq_early: got %b want 0", mac_if.send_irq); end
      step();
      n_cmp++; if (mac_if.send_irq !== 1'b1) begin n_bad++; $display("FAIL single_irq: got %b want 1", mac_if.send_irq); end
      n_cmp++; if (mac_if.port_id !== 2'd0) begin n_bad++; $display("FAIL single_port_id: got %0d want 0", mac_if.port_id); end
      n_cmp++; if (mac_if.length !== 10'd64) begin n_bad++; $display("FAIL single_length: got %0d want 64", mac_if.length); end
      n_cmp++; if (dbg_state !== S_WAIT_DN) begin n_bad++; $display("FAIL single_state: got %0d want %0d", dbg_state, S_WAIT_DN); end
      step();
      n_cmp++; if (mac_if.send_irq !== 1'b0) begin n_bad++; $display("FAIL single_irq_pulse: got %b want 0", mac_if.send_irq); end
      mac_if.send_dn = 1'b1;
      step();
      n_cmp++; if (done !== 3'b001) begin n_bad++; $display("FAIL single_done: got %b want 001", done); end
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL single_grant_hold: got %b want 001", grant); end
      mac_if.send_dn = 1'b0;
      req = 3'b000;
      step();
      n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL single_done_pulse: got %b want 000", done); end
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL single_grant_drop: got %b want 000", grant); end
   endtask

   task automatic test_fairness();
      int  exp_id[4]  = '{0, 1, 2, 0};
      int  exp_len[4] = '{10, 20, 30, 10};
      bit  ok;
      do_reset();
      len_bus = {10'd30, 10'd20, 10'd10};
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         ok = 1'b0;
         for (int c = 0; c < 8; c++) begin
            step();
            if (mac_if.send_irq === 1'b1) begin ok = 1'b1; break; end
         end
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_launch[%0d]: got no send_irq want send_irq within 8 cycles", i); end
         n_cmp++; if (mac_if.port_id !== 2'(exp_id[i])) begin n_bad++; $display("FAIL fair_port_id[%0d]: got %0d want %0d", i, mac_if.port_id, exp_id[i]); end
         n_cmp++; if (mac_if.length !== 10'(exp_len[i])) begin n_bad++; $display("FAIL fair_length[%0d]: got %0d want %0d", i, mac_if.length, exp_len[i]); end
         n_cmp++; if (grant !== 3'(1 << exp_id[i])) begin n_bad++; $display("FAIL fair_grant[%0d]: got %b want %b", i, grant, 3'(1 << exp_id[i])); end
         step();
         mac_if.send_dn = 1'b1;
         step();
         mac_if.send_dn = 1'b0;
         n_cmp++; if (done !== 3'(1 << exp_id[i])) begin n_bad++; $display("FAIL fair_done[%0d]: got %b want %b", i, done, 3'(1 << exp_id[i])); end
         step();
      end
      req = 3'b000;
      step();
   endtask

   task automatic test_reject();
      do_reset();
      len_bus[19:10] = 10'd758;
      req = 3'b010;
      step();
      n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL rej_grant1: got %b want 010", grant); end
      step();
      n_cmp++; if (err !== 3'b010) begin n_bad++; $display("FAIL rej_err1: got %b want 010", err); end
      n_cmp++; if (mac_if.send_irq !== 1'b0) begin n_bad++; $display("FAIL rej_irq1: got %b want 0", mac_if.send_irq); end
      n_cmp++; if (dbg_state !== S_RELEASE) begin n_bad++; $display("FAIL rej_state: got %0d want %0d", dbg_state, S_RELEASE); end
      len_bus[29:20] = 10'd0;
      len_bus[9:0]   = 10'd10;
      req = 3'b101;
      step();
      n_cmp++; if (err !== 3'b000) begin n_bad++; $display("FAIL rej_err_pulse: got %b want 000", err); end
      step();
      n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL rej_grant2: got %b want 100", grant); end
      step();
      n_cmp++; if (err !== 3'b100) begin n_bad++; $display("FAIL rej_err2: got %b want 100", err); end
      n_cmp++; if (mac_if.send_irq !== 1'b0) begin n_bad++; $display("FAIL rej_irq2: got %b want 0", mac_if.send_irq); end
      req = 3'b001;
      step();
      step();
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL rej_wrap_grant: got %b want 001", grant); end
      step();
      n_cmp++; if (mac_if.send_irq !== 1'b1) begin n_bad++; $display("FAIL rej_wrap_irq: got %b want 1", mac_if.send_irq); end
      n_cmp++; if (mac_if.length !== 10'd10) begin n_bad++; $display("FAIL rej_wrap_length: got %0d want 10", mac_if.length); end
      finish_frame();
   endtask

   task automatic test_data_routing();
      do_reset();
      len_bus[29:20] = 10'd757;
      rd_bus = {16'hC0DE, 16'h1111, 16'h2222};
      mac_if.mac_addr = 10'd5;
      req = 3'b100;
      #1;
      n_cmp++; if (mac_if.data !== 16'h0000) begin n_bad++; $display("FAIL route_nogrant: got %h want 0000", mac_if.data); end
      step();
      step();
      n_cmp++; if (mac_if.send_irq !== 1'b1) begin n_bad++; $display("FAIL route_irq_max_len: got %b want 1", mac_if.send_irq); end
      n_cmp++; if (mac_if.length !== 10'd757) begin n_bad++; $display("FAIL route_length: got %0d want 757", mac_if.length); end
      n_cmp++; if (mac_if.port_id !== 2'd2) begin n_bad++; $display("FAIL route_port_id: got %0d want 2", mac_if.port_id); end
      n_cmp++; if (rd_addr !== 10'd5) begin n_bad++; $display("FAIL route_addr: got %0d want 5", rd_addr); end
      n_cmp++; if (mac_if.data !== 16'hC0DE) begin n_bad++; $display("FAIL route_data: got %h want c0de", mac_if.data); end
      rd_bus[31:0] = {16'h5555, 16'hAAAA};
      #1;
      n_cmp++; if (mac_if.data !== 16'hC0DE) begin n_bad++; $display("FAIL route_isolate: got %h want c0de", mac_if.data); end
      rd_bus[47:32] = 16'hBEEF;
      mac_if.mac_addr = 10'h3FF;
      #1;
      n_cmp++; if (mac_if.data !== 16'hBEEF) begin n_bad++; $display("FAIL route_follow: got %h want beef", mac_if.data); end
      n_cmp++; if (rd_addr !== 10'h3FF) begin n_bad++; $display("FAIL route_addr2: got %h want 3ff", rd_addr); end
      finish_frame();
      n_cmp++; if (mac_if.data !== 16'h0000) begin n_bad++; $display("FAIL route_released: got %h want 0000", mac_if.data); end
   endtask

   task automatic test_mac_busy();
      do_reset();
      mac_if.send_idl = 1'b0;
      len_bus[9:0] = 10'd8;
      req = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL busy_grant[%0d]: got %b want 000", i, grant); end
      end
      mac_if.send_idl = 1'b1;
      step();
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL busy_release_grant: got %b want 001", grant); end
      step();
      n_cmp++; if (mac_if.send_irq !== 1'b1) begin n_bad++; $display("FAIL busy_irq: got %b want 1", mac_if.send_irq); end
      finish_frame();
   endtask

   task automatic test_back_to_back();
      do_reset();
      mac_if.send_dn = 1'b1;
      step();
      mac_if.send_dn = 1'b0;
      n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL b2b_stray_dn: got %b want 000", done); end
      len_bus = {10'd13, 10'd12, 10'd11};
      req = 3'b001;
      step();
      step();
      step();
      req = 3'b011;
      mac_if.send_dn = 1'b1;
      step();
      n_cmp++; if (done !== 3'b001) begin n_bad++; $display("FAIL b2b_done: got %b want 001", done); end
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL b2b_grant_hold: got %b want 001", grant); end
      mac_if.send_dn = 1'b0;
      req = 3'b010;
      step();
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL b2b_release: got %b want 000", grant); end
      step();
      n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL b2b_next_grant: got %b want 010", grant); end
      step();
      n_cmp++; if (mac_if.port_id !== 2'd1) begin n_bad++; $display("FAIL b2b_port_id: got %0d want 1", mac_if.port_id); end
      n_cmp++; if (mac_if.length !== 10'd12) begin n_bad++; $display("FAIL b2b_length: got %0d want 12", mac_if.length); end
      finish_frame();
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      len_bus[19:10] = 10'd33;
      req = 3'b010;
      step();
      step();
      step();
      n_cmp++; if (dbg_state !== S_WAIT_DN) begin n_bad++; $display("FAIL midrst_pre_state: got %0d want %0d", dbg_state, S_WAIT_DN); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL midrst_grant: got %b want 000", grant); end
      n_cmp++; if (mac_if.length !== 10'd0) begin n_bad++; $display("FAIL midrst_length: got %0d want 0", mac_if.length); end
      n_cmp++; if (mac_if.port_id !== 2'd0) begin n_bad++; $display("FAIL midrst_port_id: got %0d want 0", mac_if.port_id); end
      n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, S_IDLE); end
      req = 3'b000;
      step();
      rst_n = 1'b1;
      step();
   endtask

`ifdef TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      len_bus[9:0] = 10'd4;
      req = 3'b001;
      step();
      step();
      for (int i = 0; i < 15; i++) begin
         step();
         n_cmp++; if (err !== 3'b000) begin n_bad++; $display("FAIL tmo_early[%0d]: got %b want 000", i, err); end
      end
      step();
      n_cmp++; if (err !== 3'b001) begin n_bad++; $display("FAIL tmo_err: got %b want 001", err); end
      n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", timeout); end
      req = 3'b000;
      step();
      n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", timeout); end
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL tmo_release: got %b want 000", grant); end
      req = 3'b001;
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_rst_flag: got %b want 0", timeout); end
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL tmo_rst_grant: got %b want 000", grant); end
      req = 3'b000;
      step();
      rst_n = 1'b1;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_reject();
      test_data_routing();
      test_mac_busy();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef TX_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
